// File: rtl/array_2d_bist.sv
// array_2d_bist: fill-and-check sequencer for a WA x WC array of WB-bit words.
// A run clears every cell to FILL, then writes the {row, col} pattern into a
// wa x wc corner region, then reads the whole array back and counts mismatches.
// The first failing address and its read data are also captured.
module array_2d_bist #(
    parameter int            WA   = 8,
    parameter int            WC   = 8,
    parameter int            WB   = 8,
    parameter logic [WB-1:0] FILL = {WB{1'b1}},
    localparam int AW = $clog2(WA),
    localparam int CW = $clog2(WC),
    localparam int EW = $clog2(WA*WC+1),
    localparam int RW = $clog2(WA+1),
    localparam int KW = $clog2(WC+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [RW-1:0] wa,
    input  logic [KW-1:0] wc,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [EW-1:0] err_cnt,
    output logic [AW-1:0] err_row,
    output logic [CW-1:0] err_col,
    output logic [WB-1:0] err_data,
    output logic [AW-1:0] mem_row,
    output logic [CW-1:0] mem_col,
    output logic          mem_we,
    output logic [WB-1:0] mem_wdata,
    output logic          mem_re,
    input  logic [WB-1:0] mem_rdata
);

    localparam int            HW       = WB / 2;
    localparam logic [AW-1:0] LAST_ROW = AW'(WA - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(WC - 1);
    localparam logic [RW-1:0] WA_MAX   = RW'(WA);
    localparam logic [KW-1:0] WC_MAX   = KW'(WC);

    typedef enum logic [2:0] {IDLE, CLEAR, WRITE, READ, FLUSH, DONE} state_t;

    state_t        state;
    logic [RW-1:0] wa_lat;
    logic [KW-1:0] wc_lat;
    logic [RW-1:0] wa_sat;
    logic [KW-1:0] wc_sat;
    logic [RW-1:0] row_inc;
    logic [KW-1:0] col_inc;
    logic          in_region;
    logic          last_cell;
    logic [WB-1:0] exp_now;
    logic          cmp_valid;
    logic [AW-1:0] cmp_row;
    logic [CW-1:0] cmp_col;
    logic [WB-1:0] cmp_exp;
    logic          mismatch;
    logic [EW-1:0] err_cnt_nxt;

    // The word written into the pattern region: low half of row above low half of col.
    function automatic logic [WB-1:0] pattern(input logic [AW-1:0] r, input logic [CW-1:0] c);
        logic [HW-1:0] rh;
        logic [HW-1:0] ch;
        rh = HW'(r);
        ch = HW'(c);
        return {rh, ch};
    endfunction

    // Region saturation, address stepping, expected data and the readback compare.
    always_comb begin
        wa_sat      = (wa > WA_MAX) ? WA_MAX : wa;
        wc_sat      = (wc > WC_MAX) ? WC_MAX : wc;
        row_inc     = RW'(mem_row) + RW'(1);
        col_inc     = KW'(mem_col) + KW'(1);
        in_region   = (RW'(mem_row) < wa_lat) && (KW'(mem_col) < wc_lat);
        exp_now     = in_region ? pattern(mem_row, mem_col) : FILL;
        last_cell   = (mem_row == LAST_ROW) && (mem_col == LAST_COL);
        mismatch    = cmp_valid && (mem_rdata !== cmp_exp);
        err_cnt_nxt = mismatch ? err_cnt + EW'(1) : err_cnt;
    end

    // Sequencer with registered memory-port outputs plus the one-deep compare pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wa_lat    <= '0;
            wc_lat    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            err_row   <= '0;
            err_col   <= '0;
            err_data  <= '0;
            mem_row   <= '0;
            mem_col   <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_re    <= 1'b0;
            cmp_valid <= 1'b0;
            cmp_row   <= '0;
            cmp_col   <= '0;
            cmp_exp   <= '0;
        end else begin
            cmp_valid <= mem_re;
            cmp_row   <= mem_row;
            cmp_col   <= mem_col;
            cmp_exp   <= exp_now;
            if (mismatch) begin
                err_cnt <= err_cnt_nxt;
                if (err_cnt == '0) begin
                    err_row  <= cmp_row;
                    err_col  <= cmp_col;
                    err_data <= mem_rdata;
                end
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        wa_lat    <= wa_sat;
                        wc_lat    <= wc_sat;
                        err_cnt   <= '0;
                        err_row   <= '0;
                        err_col   <= '0;
                        err_data  <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        mem_row   <= '0;
                        mem_col   <= '0;
                        mem_we    <= 1'b1;
                        mem_wdata <= FILL;
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (last_cell) begin
                        mem_row <= '0;
                        mem_col <= '0;
                        if (wa_lat == '0 || wc_lat == '0) begin
                            mem_we <= 1'b0;
                            mem_re <= 1'b1;
                            state  <= READ;
                        end else begin
                            mem_wdata <= pattern('0, '0);
                            state     <= WRITE;
                        end
                    end else if (mem_col == LAST_COL) begin
                        mem_row <= mem_row + AW'(1);
                        mem_col <= '0;
                    end else begin
                        mem_col <= mem_col + CW'(1);
                    end
                end
                WRITE: begin
                    if (col_inc < wc_lat) begin
                        mem_col   <= mem_col + CW'(1);
                        mem_wdata <= pattern(mem_row, mem_col + CW'(1));
                    end else if (row_inc < wa_lat) begin
                        mem_row   <= mem_row + AW'(1);
                        mem_col   <= '0;
                        mem_wdata <= pattern(mem_row + AW'(1), '0);
                    end else begin
                        mem_row <= '0;
                        mem_col <= '0;
                        mem_we  <= 1'b0;
                        mem_re  <= 1'b1;
                        state   <= READ;
                    end
                end
                READ: begin
                    if (last_cell) begin
                        mem_re <= 1'b0;
                        state  <= FLUSH;
                    end else if (mem_col == LAST_COL) begin
                        mem_row <= mem_row + AW'(1);
                        mem_col <= '0;
                    end else begin
                        mem_col <= mem_col + CW'(1);
                    end
                end
                FLUSH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_cnt_nxt == '0);
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
